exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//   Execute stage; sits directly downstream of the ID/EXE pipeline register.
//   - Forwards operands from EXE/MEM and MEM/WB.
//   - Runs the 3-bit ALU and resolves BEQ/JAL, redirecting fetch and flushing younger stages.
//   - Registers results into the EXE/MEM pipeline register (1-cycle latency).
//   - Keeps a saturating taken-redirect counter.
// PARAMETERS
//   DSIZE  32  data width; equals `DSIZE in define.v
//   ASIZE  5   register address width; equals `ASIZE
//   ISIZE  32  PC/instruction width; equals `ISIZE
// PORTS
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous, active-high reset
//   rdata1_in     in   DSIZE  ID/EXE operand A
//   rdata2_in     in   DSIZE  ID/EXE operand B (register)
//   rdata2_imm_in in   DSIZE  ID/EXE operand B already muxed with immediate
//   imm_in        in   DSIZE  sign-extended immediate / jump target
//   raddr1_in     in   ASIZE  source reg A; raddr2_in in ASIZE source reg B
//   use_imm_in    in   1      1: ALU B = rdata2_imm_in (no forwarding on B-ALU path)
//   waddr_in, nPC_in[ISIZE], aluop_in[3], wen_in, memwrite_in, memread_in,
//   memtoreg_in, branch_in, jal_in   in   ID/EXE control, as named
//   mem_fwd_data  in   DSIZE  ALU result held in EXE/MEM (= alu_result_out)
//   wb_wdata      in   DSIZE  write-back data; wb_waddr in ASIZE; wb_wen in 1
//   stall_in      in   1      memory stall: hold EXE/MEM, suppress redirect
//   alu_result_out out DSIZE  EXE/MEM: ALU result, or nPC for JAL
//   store_data_out out DSIZE  EXE/MEM: forwarded operand B for stores
//   waddr_out, wen_out, memwrite_out, memread_out, memtoreg_out   out   EXE/MEM control
//   pc_sel_out    out  1      comb: redirect fetch this cycle
//   pc_target_out out  ISIZE  comb: redirect target
//   flush_out     out  1      comb: clear IF/ID and ID/EXE on next edge (= pc_sel_out)
//   redirect_cnt  out  16     saturating count of redirects taken
// BEHAVIOUR
//   - Reset: every registered output, including redirect_cnt, is 0 on the first edge with rst=1.
//     Reset overrides stall_in. Comb outputs are 0 while ID/EXE holds its reset bubble.
//   - Forwarding for srcA and for B when use_imm_in=0:
//     - if wen_out && !memtoreg_out && waddr_out==src && src!=0 -> mem_fwd_data;
//     - else if wb_wen && wb_waddr==src && src!=0 -> wb_wdata;
//     - else the ID/EXE value.
//     EXE/MEM has priority over MEM/WB. Register 0 is never forwarded.
//     Load-use hazards belong to the ID hazard unit, not this block.
//   - store_data_out always takes forwarded B, independent of use_imm_in.
//   - ALU, result width DSIZE, wrap-around:
//     - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR;
//     - 101 SLT: signed, result 1/0;
//     - 110 SLL by B[4:0]; 111 SRL (logical) by B[4:0].
//   - Branch:
//     - taken = branch_in && (fwdA == fwdB); target = nPC_in + imm_in[ISIZE-1:0].
//     - JAL: taken = 1, target = imm_in[ISIZE-1:0], alu_result = nPC_in.
//     - JAL has priority if both branch_in and jal_in are set.
//   - pc_sel_out = taken && !stall_in && !rst; flush_out = pc_sel_out.
//   - Pipeline register:
//     - stall_in=1: all EXE/MEM outputs and redirect_cnt hold.
//     - else capture next values. Branch ops capture wen=0, memwrite=0.
//   - redirect_cnt increments on each pc_sel_out cycle; saturates at 16'hFFFF.
//   - Stall + taken same cycle: no redirect; it fires on the first unstalled cycle,
//     since ID/EXE also holds.
// STRUCTURE
//   - define.v gains ALU opcode macros: `ALU_ADD..`ALU_SRL.
//   - Sub-module alu_unit: combinational, (a, b, aluop) -> result.
//   - Forwarding muxes, branch logic, EXE/MEM register and counter live in exe_stage.
// TESTING
//   1. ADD r3=r1+r2 back-to-back with SUB r4=r3-r1 (r1=5, r2=7)
//      -> second result 7 via EXE/MEM forward.
//   2. wen_out=1, waddr_out=0, raddr1_in=0, rdata1_in=0, mem_fwd_data=99
//      -> operand A = 0, no forward.
//   3. BEQ fwdA=fwdB=4, nPC=0x100, imm=0x20 -> pc_sel=1, target 0x120, flush=1,
//      redirect_cnt 0->1. Unequal operands -> pc_sel=0.
//   4. JAL nPC=0x44, imm=0x200 with stall_in=1 for 2 cycles -> no redirect, outputs hold;
//      third cycle: target 0x200, alu_result_out=0x44.
//   5. SLT A=-1, B=1 -> 1; SRL A=0x80000000, B=31 -> 1; ADD 0xFFFFFFFF+1 -> 0.
//   6. rst asserted mid-stream with stall_in=1 -> all outputs 0 next edge, redirect_cnt=0.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU opcodes and the forwarding-match helper for the execute stage.
package exe_stage_pkg;

    localparam int DSIZE = 32;
    localparam int ASIZE = 5;
    localparam int ISIZE = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } aluop_t;

    // A later stage supplies src when it writes that register; r0 is hard-wired zero.
    function automatic logic fwd_hit(input logic en, input logic [ASIZE-1:0] waddr,
                                     input logic [ASIZE-1:0] src);
        return en && (waddr == src) && (src != '0);
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Bundle of the ID/EXE inputs, forwarding sources and EXE/MEM outputs of the execute stage.
// There is no valid/ready pair: every ID/EXE slot is a real instruction or a zero bubble,
// and stall_in is the only flow control. While stall_in=1 the EXE/MEM register and the
// redirect counter hold and no redirect is issued.
interface exe_stage_if;
    import exe_stage_pkg::*;

    // ID/EXE pipeline register
    logic [DSIZE-1:0] rdata1_in;
    logic [DSIZE-1:0] rdata2_in;
    logic [DSIZE-1:0] rdata2_imm_in;
    logic [DSIZE-1:0] imm_in;
    logic [ASIZE-1:0] raddr1_in;
    logic [ASIZE-1:0] raddr2_in;
    logic             use_imm_in;
    logic [ASIZE-1:0] waddr_in;
    logic [ISIZE-1:0] nPC_in;
    logic [2:0]       aluop_in;
    logic             wen_in;
    logic             memwrite_in;
    logic             memread_in;
    logic             memtoreg_in;
    logic             branch_in;
    logic             jal_in;
    // forwarding sources and stall
    logic [DSIZE-1:0] mem_fwd_data;
    logic [DSIZE-1:0] wb_wdata;
    logic [ASIZE-1:0] wb_waddr;
    logic             wb_wen;
    logic             stall_in;
    // EXE/MEM pipeline register and redirect
    logic [DSIZE-1:0] alu_result_out;
    logic [DSIZE-1:0] store_data_out;
    logic [ASIZE-1:0] waddr_out;
    logic             wen_out;
    logic             memwrite_out;
    logic             memread_out;
    logic             memtoreg_out;
    logic             pc_sel_out;
    logic [ISIZE-1:0] pc_target_out;
    logic             flush_out;
    logic [15:0]      redirect_cnt;

    modport master (
        output rdata1_in, rdata2_in, rdata2_imm_in, imm_in, raddr1_in, raddr2_in,
               use_imm_in, waddr_in, nPC_in, aluop_in, wen_in, memwrite_in, memread_in,
               memtoreg_in, branch_in, jal_in, mem_fwd_data, wb_wdata, wb_waddr, wb_wen,
               stall_in,
        input  alu_result_out, store_data_out, waddr_out, wen_out, memwrite_out,
               memread_out, memtoreg_out, pc_sel_out, pc_target_out, flush_out,
               redirect_cnt
    );

    modport slave (
        input  rdata1_in, rdata2_in, rdata2_imm_in, imm_in, raddr1_in, raddr2_in,
               use_imm_in, waddr_in, nPC_in, aluop_in, wen_in, memwrite_in, memread_in,
               memtoreg_in, branch_in, jal_in, mem_fwd_data, wb_wdata, wb_waddr, wb_wen,
               stall_in,
        output alu_result_out, store_data_out, waddr_out, wen_out, memwrite_out,
               memread_out, memtoreg_out, pc_sel_out, pc_target_out, flush_out,
               redirect_cnt
    );

endinterface

// File: rtl/exe_stage_alu_unit.sv
// Combinational ALU; all arithmetic wraps, shifts use only b[4:0].
module alu_unit import exe_stage_pkg::*; (
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    input  aluop_t           aluop,
    output logic [DSIZE-1:0] result
);

    // Opcode decode
    always_comb begin
        result = '0;
        case (aluop)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(DSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, BEQ/JAL resolution, EXE/MEM register and
// a saturating count of redirects taken.
module exe_stage (
    input logic       clk,
    input logic       rst,
    exe_stage_if.slave bus
);
    import exe_stage_pkg::*;

    logic [DSIZE-1:0] fwd_a;
    logic [DSIZE-1:0] fwd_b;
    logic [DSIZE-1:0] alu_b;
    logic [DSIZE-1:0] alu_res;
    logic             taken;
    logic [ISIZE-1:0] target;
    logic             mem_can_fwd;

    // A load in EXE/MEM has no data yet; its value comes later via write-back.
    assign mem_can_fwd = bus.wen_out && !bus.memtoreg_out;

    // Forwarding muxes: EXE/MEM beats MEM/WB, r0 never forwarded
    always_comb begin
        fwd_a = bus.rdata1_in;
        if (fwd_hit(mem_can_fwd, bus.waddr_out, bus.raddr1_in))
            fwd_a = bus.mem_fwd_data;
        else if (fwd_hit(bus.wb_wen, bus.wb_waddr, bus.raddr1_in))
            fwd_a = bus.wb_wdata;

        fwd_b = bus.rdata2_in;
        if (fwd_hit(mem_can_fwd, bus.waddr_out, bus.raddr2_in))
            fwd_b = bus.mem_fwd_data;
        else if (fwd_hit(bus.wb_wen, bus.wb_waddr, bus.raddr2_in))
            fwd_b = bus.wb_wdata;
    end

    // The immediate path arrives pre-muxed from ID and bypasses forwarding.
    assign alu_b = bus.use_imm_in ? bus.rdata2_imm_in : fwd_b;

    alu_unit u_alu (
        .a      (fwd_a),
        .b      (alu_b),
        .aluop  (aluop_t'(bus.aluop_in)),
        .result (alu_res)
    );

    // Branch resolution: JAL wins over BEQ when both are set
    always_comb begin
        taken  = 1'b0;
        target = bus.nPC_in + bus.imm_in[ISIZE-1:0];
        if (bus.jal_in) begin
            taken  = 1'b1;
            target = bus.imm_in[ISIZE-1:0];
        end else if (bus.branch_in) begin
            taken  = (fwd_a == fwd_b);
        end
    end

    // A stalled redirect is not lost: ID/EXE holds it until the stall clears.
    assign bus.pc_sel_out    = taken && !bus.stall_in && !rst;
    assign bus.flush_out     = bus.pc_sel_out;
    assign bus.pc_target_out = target;

    // EXE/MEM pipeline register; BEQ never writes a register or memory
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_result_out <= '0;
            bus.store_data_out <= '0;
            bus.waddr_out      <= '0;
            bus.wen_out        <= 1'b0;
            bus.memwrite_out   <= 1'b0;
            bus.memread_out    <= 1'b0;
            bus.memtoreg_out   <= 1'b0;
        end else if (!bus.stall_in) begin
            bus.alu_result_out <= bus.jal_in ? bus.nPC_in : alu_res;
            bus.store_data_out <= fwd_b;
            bus.waddr_out      <= bus.waddr_in;
            bus.wen_out        <= bus.wen_in && !(bus.branch_in && !bus.jal_in);
            bus.memwrite_out   <= bus.memwrite_in && !(bus.branch_in || bus.jal_in);
            bus.memread_out    <= bus.memread_in;
            bus.memtoreg_out   <= bus.memtoreg_in;
        end
    end

    // Saturating redirect counter; pc_sel_out already excludes stall and reset
    always_ff @(posedge clk) begin
        if (rst)
            bus.redirect_cnt <= '0;
        else if (bus.pc_sel_out && (bus.redirect_cnt != 16'hFFFF))
            bus.redirect_cnt <= bus.redirect_cnt + 16'd1;
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: forwarding, r0, BEQ, JAL under stall, ALU corners, reset.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    exe_stage_if bus ();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: zero bubble on every ID/EXE and forwarding input
    task automatic drive_idle();
        bus.rdata1_in = '0; bus.rdata2_in = '0; bus.rdata2_imm_in = '0; bus.imm_in = '0;
        bus.raddr1_in = '0; bus.raddr2_in = '0; bus.use_imm_in = 1'b0; bus.waddr_in = '0;
        bus.nPC_in = '0; bus.aluop_in = ALU_ADD; bus.wen_in = 1'b0; bus.memwrite_in = 1'b0;
        bus.memread_in = 1'b0; bus.memtoreg_in = 1'b0; bus.branch_in = 1'b0; bus.jal_in = 1'b0;
        bus.mem_fwd_data = '0; bus.wb_wdata = '0; bus.wb_waddr = '0; bus.wb_wen = 1'b0;
        bus.stall_in = 1'b0;
    endtask

    // driver: register-register ALU op with no forwarding sources active
    task automatic drive_rr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wa);
        drive_idle();
        bus.aluop_in = op; bus.rdata1_in = a; bus.rdata2_in = b;
        bus.waddr_in = wa; bus.wen_in = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.alu_result_out, bus.store_data_out, bus.waddr_out, bus.wen_out, bus.memwrite_out,
             bus.memread_out, bus.memtoreg_out} !== '0) begin
            n_bad++; $display("FAIL reset_regs: got %h/%h wen=%b required all 0",
                              bus.alu_result_out, bus.store_data_out, bus.wen_out);
        end
        n_cmp++;
        if (bus.redirect_cnt !== 16'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d required 0", bus.redirect_cnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.pc_sel_out, bus.flush_out, bus.pc_target_out} !== '0) begin
            n_bad++; $display("FAIL reset_comb: pc_sel=%b target=%h required 0/0",
                              bus.pc_sel_out, bus.pc_target_out);
        end
    endtask

    task automatic test_forwarding();
        // ADD r3 = r1 + r2
        drive_rr(ALU_ADD, 32'd5, 32'd7, 5'd3);
        bus.raddr1_in = 5'd1; bus.raddr2_in = 5'd2;
        tick();
        n_cmp++;
        if (bus.alu_result_out !== 32'd12 || bus.waddr_out !== 5'd3 || bus.wen_out !== 1'b1) begin
            n_bad++; $display("FAIL fwd_add: got %0d wa=%0d wen=%b required 12 3 1",
                              bus.alu_result_out, bus.waddr_out, bus.wen_out);
        end
        // SUB r4 = r3 - r1, r3 stale in ID/EXE, comes from EXE/MEM
        drive_rr(ALU_SUB, 32'd0, 32'd5, 5'd4);
        bus.raddr1_in = 5'd3; bus.raddr2_in = 5'd1; bus.mem_fwd_data = 32'd12;
        tick();
        n_cmp++;
        if (bus.alu_result_out !== 32'd7) begin
            n_bad++; $display("FAIL fwd_sub_exmem: got %0d required 7", bus.alu_result_out);
        end
        // both stages hold r4: EXE/MEM wins; B via immediate, store still forwards
        drive_rr(ALU_ADD, 32'd1, 32'd9, 5'd5);
        bus.raddr1_in = 5'd4; bus.raddr2_in = 5'd4; bus.mem_fwd_data = 32'd100;
        bus.wb_wen = 1'b1; bus.wb_waddr = 5'd4; bus.wb_wdata = 32'd200;
        bus.use_imm_in = 1'b1; bus.rdata2_imm_in = 32'd3; bus.memtoreg_in = 1'b1;
        tick();
        n_cmp++;
        if (bus.alu_result_out !== 32'd103) begin
            n_bad++; $display("FAIL fwd_priority: got %0d required 103", bus.alu_result_out);
        end
        n_cmp++;
        if (bus.store_data_out !== 32'd100 || bus.memtoreg_out !== 1'b1) begin
            n_bad++; $display("FAIL fwd_store_imm: got %0d mtr=%b required 100 1",
                              bus.store_data_out, bus.memtoreg_out);
        end
        // EXE/MEM is a load into r5: both operands must come from write-back
        drive_rr(ALU_ADD, 32'd1, 32'd2, 5'd6);
        bus.raddr1_in = 5'd5; bus.raddr2_in = 5'd5; bus.mem_fwd_data = 32'd77;
        bus.wb_wen = 1'b1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'd30;
        tick();
        n_cmp++;
        if (bus.alu_result_out !== 32'd60 || bus.store_data_out !== 32'd30) begin
            n_bad++; $display("FAIL fwd_wb_load: got %0d/%0d required 60/30",
                              bus.alu_result_out, bus.store_data_out);
        end
    endtask

    task automatic test_reg_zero();
        drive_rr(ALU_ADD, 32'd0, 32'd0, 5'd0);
        tick();
        n_cmp++;
        if (bus.wen_out !== 1'b1 || bus.waddr_out !== 5'd0) begin
            n_bad++; $display("FAIL r0_setup: wen=%b wa=%0d required 1 0", bus.wen_out, bus.waddr_out);
        end
        drive_rr(ALU_ADD, 32'd0, 32'd0, 5'd8);
        bus.mem_fwd_data = 32'd99;
        bus.wb_wen = 1'b1; bus.wb_waddr = 5'd0; bus.wb_wdata = 32'd55;
        tick();
        n_cmp++;
        if (bus.alu_result_out !== 32'd0 || bus.store_data_out !== 32'd0) begin
            n_bad++; $display("FAIL r0_no_fwd: got %0d/%0d required 0/0",
                              bus.alu_result_out, bus.store_data_out);
        end
    endtask

    task automatic test_beq();
        drive_rr(ALU_SUB, 32'd4, 32'd4, 5'd9);
        bus.branch_in = 1'b1; bus.memwrite_in = 1'b1;
        bus.nPC_in = 32'h100; bus.imm_in = 32'h20;
        #1;
        n_cmp++;
        if (bus.pc_sel_out !== 1'b1 || bus.flush_out !== 1'b1 || bus.pc_target_out !== 32'h120) begin
            n_bad++; $display("FAIL beq_taken: sel=%b flush=%b tgt=%h required 1 1 120",
                              bus.pc_sel_out, bus.flush_out, bus.pc_target_out);
        end
        tick();
        n_cmp++;
        if (bus.redirect_cnt !== 16'd1 || bus.wen_out !== 1'b0 || bus.memwrite_out !== 1'b0) begin
            n_bad++; $display("FAIL beq_regs: cnt=%0d wen=%b mw=%b required 1 0 0",
                              bus.redirect_cnt, bus.wen_out, bus.memwrite_out);
        end
        bus.rdata2_in = 32'd5;
        #1;
        n_cmp++;
        if (bus.pc_sel_out !== 1'b0 || bus.flush_out !== 1'b0) begin
            n_bad++; $display("FAIL beq_not_taken: sel=%b flush=%b required 0 0",
                              bus.pc_sel_out, bus.flush_out);
        end
        tick();
        n_cmp++;
        if (bus.redirect_cnt !== 16'd1) begin
            n_bad++; $display("FAIL beq_nt_cnt: got %0d required 1", bus.redirect_cnt);
        end
    endtask

    task automatic test_jal_stall();
        drive_rr(ALU_ADD, 32'd3, 32'd4, 5'd7);
        tick();
        // JAL with BEQ also set on unequal operands, held by a two-cycle stall
        drive_rr(ALU_ADD, 32'd1, 32'd2, 5'd1);
        bus.jal_in = 1'b1; bus.branch_in = 1'b1;
        bus.nPC_in = 32'h44; bus.imm_in = 32'h200; bus.stall_in = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (bus.pc_sel_out !== 1'b0 || bus.flush_out !== 1'b0) begin
                n_bad++; $display("FAIL jal_stall_sel[%0d]: sel=%b flush=%b required 0 0",
                                  c, bus.pc_sel_out, bus.flush_out);
            end
            tick();
            n_cmp++;
            if (bus.alu_result_out !== 32'd7 || bus.waddr_out !== 5'd7 || bus.redirect_cnt !== 16'd1) begin
                n_bad++; $display("FAIL jal_stall_hold[%0d]: alu=%h wa=%0d cnt=%0d required 7 7 1",
                                  c, bus.alu_result_out, bus.waddr_out, bus.redirect_cnt);
            end
        end
        bus.stall_in = 1'b0;
        #1;
        n_cmp++;
        if (bus.pc_sel_out !== 1'b1 || bus.flush_out !== 1'b1 || bus.pc_target_out !== 32'h200) begin
            n_bad++; $display("FAIL jal_fire: sel=%b flush=%b tgt=%h required 1 1 200",
                              bus.pc_sel_out, bus.flush_out, bus.pc_target_out);
        end
        tick();
        n_cmp++;
        if (bus.alu_result_out !== 32'h44 || bus.redirect_cnt !== 16'd2) begin
            n_bad++; $display("FAIL jal_link: alu=%h cnt=%0d required 44 2",
                              bus.alu_result_out, bus.redirect_cnt);
        end
    endtask

    task automatic test_alu();
        logic [2:0]  ops [10];
        logic [31:0] av  [10];
        logic [31:0] bv  [10];
        logic [31:0] ex  [10];
        ops = '{ALU_SLT, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
                ALU_OR, ALU_XOR, ALU_SLL, ALU_SLT, ALU_SRL};
        av  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'hF0F0,
                32'hF0F0, 32'hFFFF, 32'h1, 32'h1, 32'h8000_0000};
        bv  = '{32'h1, 32'd31, 32'h1, 32'h1, 32'hFF00,
                32'h0F0F, 32'h0F0F, 32'h24, 32'hFFFF_FFFF, 32'h21};
        ex  = '{32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'hF000,
                32'hFFFF, 32'hF0F0, 32'h10, 32'h0, 32'h4000_0000};
        for (int i = 0; i < 10; i++) begin
            drive_rr(ops[i], av[i], bv[i], 5'd10);
            tick();
            n_cmp++;
            if (bus.alu_result_out !== ex[i]) begin
                n_bad++; $display("FAIL alu[%0d] op=%0d: got %h required %h",
                                  i, ops[i], bus.alu_result_out, ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_rr(ALU_ADD, 32'd20, 32'd22, 5'd11);
        bus.memread_in = 1'b1; bus.memtoreg_in = 1'b1;
        tick();
        n_cmp++;
        if (bus.alu_result_out !== 32'd42 || bus.redirect_cnt !== 16'd2) begin
            n_bad++; $display("FAIL rstmid_setup: alu=%0d cnt=%0d required 42 2",
                              bus.alu_result_out, bus.redirect_cnt);
        end
        bus.jal_in = 1'b1; bus.imm_in = 32'h200; bus.stall_in = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.pc_sel_out !== 1'b0 || bus.flush_out !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_sel: sel=%b flush=%b required 0 0",
                              bus.pc_sel_out, bus.flush_out);
        end
        tick();
        n_cmp++;
        if ({bus.alu_result_out, bus.store_data_out, bus.waddr_out, bus.wen_out, bus.memwrite_out,
             bus.memread_out, bus.memtoreg_out, bus.redirect_cnt} !== '0) begin
            n_bad++; $display("FAIL rstmid_regs: alu=%h wen=%b mr=%b cnt=%0d required all 0",
                              bus.alu_result_out, bus.wen_out, bus.memread_out, bus.redirect_cnt);
        end
        rst = 1'b0;
        drive_idle();
        #1;
        n_cmp++;
        if ({bus.pc_sel_out, bus.flush_out, bus.pc_target_out} !== '0) begin
            n_bad++; $display("FAIL rstmid_bubble: sel=%b tgt=%h required 0/0",
                              bus.pc_sel_out, bus.pc_target_out);
        end
    endtask

    // sequence and final report
    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_forwarding();
        test_reg_zero();
        test_beq();
        test_jal_stall();
        test_alu();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
